// File: rtl/sme_ctrl_if.sv
// rtl/sme_ctrl_if.sv - host, buffer-write, compare and result signals of the string-match sequencer
interface sme_ctrl_if;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic [7:0] buf_wdata;
  logic [4:0] buf_waddr;
  logic       str_we;
  logic       pat_we;
  logic [5:0] str_len;
  logic [3:0] pat_len;
  logic       cmp_en;
  logic [4:0] cmp_idx;
  logic       cmp_hit;
  logic       valid;
  logic       match;
  logic [4:0] match_index;

  modport master (
    input  chardata, isstring, ispattern, cmp_hit,
    output buf_wdata, buf_waddr, str_we, pat_we, str_len, pat_len,
           cmp_en, cmp_idx, valid, match, match_index
  );

  modport slave (
    output chardata, isstring, ispattern, cmp_hit,
    input  buf_wdata, buf_waddr, str_we, pat_we, str_len, pat_len,
           cmp_en, cmp_idx, valid, match, match_index
  );
endinterface

// File: rtl/sme_ctrl.sv
// rtl/sme_ctrl.sv - loads string/pattern buffers and sweeps start positions through the comparator
// SME_CTRL_EARLY_EXIT_EN: stop the sweep at the first hit instead of always covering the full string.
module sme_ctrl #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  sme_ctrl_if.master  bus
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD_STR = 3'd1;
  localparam logic [2:0] LOAD_PAT = 3'd2;
  localparam logic [2:0] SCAN     = 3'd3;
  localparam logic [2:0] DRAIN    = 3'd4;
  localparam logic [2:0] REPORT   = 3'd5;

  localparam logic [5:0] STR_FULL = 6'(STR_MAX);
  localparam logic [3:0] PAT_FULL = 4'(PAT_MAX);

  logic [2:0] state;
  logic [5:0] str_len;
  logic [3:0] pat_len;
  logic       cmp_en_q;
  logic [4:0] cmp_idx_q;
  logic       prev_en;
  logic [4:0] prev_idx;
  logic       hit_found;
  logic [4:0] hit_idx;
  logic       valid_q;
  logic       match_q;
  logic [4:0] match_index_q;

  logic       str_wr;
  logic       pat_wr;
  logic [4:0] waddr;
  logic       hit_now;
  logic       found_any;
  logic [4:0] found_idx;
  logic       last_idx;
  logic       early_stop;
  logic       to_report;

  always_comb begin
    str_wr = 1'b0;
    pat_wr = 1'b0;
    waddr  = 5'd0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (bus.isstring)       str_wr = 1'b1;
          else if (bus.ispattern) pat_wr = 1'b1;
        end
        LOAD_STR: begin
          if (bus.isstring) begin
            str_wr = (str_len < STR_FULL);
            waddr  = str_len[4:0];
          end else if (bus.ispattern) begin
            pat_wr = 1'b1;
          end
        end
        LOAD_PAT: begin
          if (bus.ispattern) begin
            pat_wr = (pat_len < PAT_FULL);
            waddr  = {1'b0, pat_len};
          end
        end
        default: ;
      endcase
    end
  end

  // cmp_hit answers for the index presented in the previous cycle, tracked by prev_en/prev_idx
  assign hit_now   = prev_en & bus.cmp_hit & ~hit_found;
  assign found_any = hit_found | hit_now;
  assign found_idx = hit_found ? hit_idx : prev_idx;
  assign last_idx  = (cmp_idx_q == 5'(str_len - 6'd1));

`ifdef SME_CTRL_EARLY_EXIT_EN
  assign early_stop = hit_now;
`else
  assign early_stop = 1'b0;
`endif

  assign to_report = (state == DRAIN) ||
                     ((state == SCAN) && ((str_len == 6'd0) || early_stop));

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      str_len       <= 6'd0;
      pat_len       <= 4'd0;
      cmp_en_q      <= 1'b0;
      cmp_idx_q     <= 5'd0;
      prev_en       <= 1'b0;
      prev_idx      <= 5'd0;
      hit_found     <= 1'b0;
      hit_idx       <= 5'd0;
      valid_q       <= 1'b0;
      match_q       <= 1'b0;
      match_index_q <= 5'd0;
    end else begin
      valid_q  <= 1'b0;
      prev_en  <= (state == SCAN) & cmp_en_q & ~early_stop;
      prev_idx <= cmp_idx_q;

      if (((state == SCAN) || (state == DRAIN)) && hit_now) begin
        hit_found <= 1'b1;
        hit_idx   <= prev_idx;
      end

      case (state)
        IDLE: begin
          if (bus.isstring) begin
            str_len <= 6'd1;
            state   <= LOAD_STR;
          end else if (bus.ispattern) begin
            pat_len <= 4'd1;
            state   <= LOAD_PAT;
          end
        end
        LOAD_STR: begin
          if (bus.isstring) begin
            if (str_len < STR_FULL) str_len <= str_len + 6'd1;
          end else if (bus.ispattern) begin
            pat_len <= 4'd1;
            state   <= LOAD_PAT;
          end else begin
            state <= IDLE;
          end
        end
        LOAD_PAT: begin
          if (bus.ispattern) begin
            if (pat_len < PAT_FULL) pat_len <= pat_len + 4'd1;
          end else begin
            state     <= SCAN;
            cmp_en_q  <= (str_len != 6'd0);
            cmp_idx_q <= 5'd0;
            hit_found <= 1'b0;
          end
        end
        SCAN: begin
          if (to_report) begin
            state     <= REPORT;
            cmp_en_q  <= 1'b0;
            cmp_idx_q <= 5'd0;
          end else if (last_idx) begin
            state     <= DRAIN;
            cmp_en_q  <= 1'b0;
            cmp_idx_q <= 5'd0;
          end else begin
            cmp_idx_q <= cmp_idx_q + 5'd1;
          end
        end
        DRAIN:   state <= REPORT;
        REPORT:  state <= IDLE;
        default: state <= IDLE;
      endcase

      if (to_report) begin
        valid_q       <= 1'b1;
        match_q       <= found_any;
        match_index_q <= found_any ? found_idx : 5'd0;
      end
    end
  end

  assign bus.buf_wdata   = bus.chardata;
  assign bus.buf_waddr   = waddr;
  assign bus.str_we      = str_wr;
  assign bus.pat_we      = pat_wr;
  assign bus.str_len     = str_len;
  assign bus.pat_len     = pat_len;
  assign bus.cmp_en      = cmp_en_q & ~early_stop;
  assign bus.cmp_idx     = cmp_idx_q;
  assign bus.valid       = valid_q;
  assign bus.match       = match_q;
  assign bus.match_index = match_index_q;
endmodule

// File: doc/sme_ctrl.md
# sme_ctrl

Control sequencer for the string-matching engine. It captures the serial string and pattern streams into the match datapath's character buffers and sweeps candidate start positions through the datapath's one-cycle comparator. It then reports one result per pattern on `valid`/`match`/`match_index`. It sits between the host character stream and the compare datapath; all pattern semantics (`^`, `$`, `.`) live in the datapath, and this block only sequences it.

## Interface
Parameters:
- `STR_MAX`, 32: string buffer depth in characters.
- `PAT_MAX`, 8: pattern buffer depth in characters.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `chardata`  in  8  host character.
- `isstring`  in  1  `chardata` is a string character this cycle.
- `ispattern`  in  1  `chardata` is a pattern character this cycle.
- `buf_wdata`  out  8  `chardata` forwarded to the datapath buffers.
- `buf_waddr`  out  5  write address (string: 0..31; pattern: 0..7).
- `str_we`  out  1  string buffer write strobe.
- `pat_we`  out  1  pattern buffer write strobe.
- `str_len`  out  6  registered count of stored string characters, 0..32.
- `pat_len`  out  4  registered count of stored pattern characters, 0..8.
- `cmp_en`  out  1  `cmp_idx` is a valid start position this cycle.
- `cmp_idx`  out  5  candidate start position.
- `cmp_hit`  in  1  datapath result for the `cmp_idx` presented one cycle earlier.
- `valid`  out  1  one-cycle result pulse.
- `match`  out  1  pattern found; meaningful only while `valid` is high.
- `match_index`  out  5  lowest matching start position; 0 when no match.

## Operation
- States: IDLE, LOAD_STR, LOAD_PAT, SCAN, DRAIN, REPORT.
- Writes are combinational from the inputs:
  - `str_we = isstring` while in IDLE or LOAD_STR.
  - `pat_we = ispattern` while in IDLE, LOAD_STR or LOAD_PAT.
  - `buf_waddr` is the current write counter; `buf_wdata = chardata`.
- IDLE:
  - `isstring` → LOAD_STR. Clears `str_len`, writes at address 0, and `str_len` becomes 1.
  - `ispattern` → LOAD_PAT. Keeps the previous string, clears `pat_len`, writes at address 0.
- LOAD_STR:
  - Each `isstring` cycle writes at address `str_len`, then increments it.
  - When `str_len` = `STR_MAX`, further characters are dropped: `str_we` stays 0 and the count saturates.
  - `ispattern` moves to LOAD_PAT with the same semantics as from IDLE.
  - Both strobes low → IDLE.
- LOAD_PAT:
  - Same as LOAD_STR, using `pat_len` and saturating at `PAT_MAX`.
  - `ispattern` low → SCAN.
- SCAN:
  - Presents `cmp_idx` = 0,1,…,`str_len`−1, one per cycle, with `cmp_en`=1.
  - After the last index → DRAIN.
  - If `str_len`=0, SCAN lasts one cycle with `cmp_en`=0 and goes straight to REPORT.
- DRAIN: samples `cmp_hit` for the final index → REPORT.
- Hit recording (SCAN and DRAIN): the first `cmp_hit`=1 records index k, the index presented one cycle earlier. Later hits never overwrite it.
- REPORT:
  - `valid`=1 for exactly one cycle, with `match` and `match_index` registered.
  - Then → IDLE; the next pattern may start the following cycle.
- Strobes during SCAN, DRAIN or REPORT are ignored: no writes and no state change. The host must wait for `valid`.
- `isstring` and `ispattern` both high: `isstring` wins in IDLE/LOAD_STR; `ispattern` wins in LOAD_PAT.
- `pat_len`=0 cannot reach SCAN.

## Timing
- Reset values:
  - State IDLE.
  - `str_len`, `pat_len`, `cmp_idx`, `cmp_en`, `valid`, `match`, `match_index` all 0.
  - `str_we`, `pat_we` 0.
- Reset mid-scan aborts the scan: no `valid` is issued, and the stored string length is lost.
- Let T be the first cycle with `ispattern` low after LOAD_PAT, and L = `str_len`:
  - `cmp_idx`=k at cycle T+k.
  - `cmp_hit` for index k is sampled at T+k+1.
  - `valid` is high at T+L+1.
  - For L=0, `valid` is high at T+1.
- `valid`, `match` and `match_index` are registered. `match` and `match_index` hold their values until the next REPORT.

## Configuration
- `SME_CTRL_EARLY_EXIT_EN` defined:
  - A hit sampled at T+k+1 ends the sweep: `cmp_en` drops in that cycle and the state goes to REPORT.
  - `valid` is high at T+k+2, with `match_index`=k.
  - A no-match result still reports at T+L+1.
- Undefined: the full sweep always runs and latency is fixed at L+1 cycles regardless of the result.

## Test plan
- String "abcab" (5 chars), pattern "ab", datapath hits at idx 0 and 3 → `valid` at T+6, `match`=1, `match_index`=0. With EARLY_EXIT, `valid` at T+2.
- Same string, pattern "zz", no hits → `valid` at T+6, `match`=0, `match_index`=0.
- 40 string characters → `str_we` high on exactly 32 cycles, `str_len`=32, sweep covers idx 0..31.
- String "xy", then patterns "y" and "x" back-to-back after each `valid` (no new string) → `str_len` stays 2; results `match_index`=1 then 0.
- Pattern with no prior string (`str_len`=0) → `cmp_en` never asserted, `valid` at T+1, `match`=0.
- `reset` asserted at T+2 during a 10-char scan → all outputs 0 next cycle, no `valid` issued; a fresh string/pattern afterwards works normally.
